// File: rtl/weyl_pkg.sv
// Shared types and the Weyl phase-to-bit-index mapping used by encoder, decoder and bench.
package weyl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } weyl_dec_state_t;

  // Bit index visited at phase i of a Weyl walk over an n-bit word.
  function automatic int unsigned weyl_idx(input int unsigned base, input int unsigned stride,
                                           input int unsigned i, input int unsigned n);
    return (base + stride * i) % n;
  endfunction

endpackage

// File: rtl/weyl_decode.sv
// Recovers the quota of a Weyl-permuted thermometer word by walking it one phase per cycle,
// and flags words whose ones are not confined to a leading run of phases.
module weyl_decode
  import weyl_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int BASE      = 61,
  parameter int STRIDE    = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BITSTREAM-1:0]         weyl_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(BITSTREAM):0]   quota_num,
  output logic                         mono_err
);

  localparam int QW = $clog2(BITSTREAM) + 1;
  localparam int IW = $clog2(BITSTREAM);
  localparam logic [IW-1:0] IDX0      = IW'(weyl_idx(BASE, STRIDE, 0, BITSTREAM));
  localparam logic [IW-1:0] IDX_STEP  = IW'(STRIDE % BITSTREAM);
  localparam logic [IW-1:0] LAST_PHASE = IW'(BITSTREAM - 1);

  if ((STRIDE % 2) == 0) begin : g_bad_stride
    $error("weyl_decode: STRIDE must be odd so the walk visits every bit");
  end
  if ((BITSTREAM < 2) || ((BITSTREAM & (BITSTREAM - 1)) != 0)) begin : g_bad_len
    $error("weyl_decode: BITSTREAM must be a power of two >= 2");
  end

  weyl_dec_state_t      state_q, state_d;
  logic [BITSTREAM-1:0] word_q, word_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        i_q, i_d;
  logic [QW-1:0]        count_q, count_d;
  logic                 err_q, err_d;
  logic                 seen0_q, seen0_d;
  logic                 bit_sel;
  logic                 load;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves one unassigned and infers a latch.
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    i_d      = i_q;
    count_d  = count_q;
    err_d    = err_q;
    seen0_d  = seen0_q;
    bit_sel  = word_q[idx_q];
    out_valid = (state_q == DONE);
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    load      = in_valid && in_ready;

    unique case (state_q)
      IDLE: ;
      SCAN: begin
        count_d = count_q + QW'(bit_sel);
        if (bit_sel && seen0_q) err_d = 1'b1;
        if (!bit_sel)           seen0_d = 1'b1;
        i_d   = i_q + 1'b1;
        // Power-of-two length: the natural IW-bit wrap is the modulo.
        idx_d = idx_q + IDX_STEP;
        if (i_q == LAST_PHASE) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load in DONE overrides the return to IDLE, giving back-to-back words.
    if (load) begin
      word_d  = weyl_in;
      count_d = '0;
      err_d   = 1'b0;
      seen0_d = 1'b0;
      i_d     = '0;
      idx_d   = IDX0;
      state_d = SCAN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX0;
      i_q     <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      seen0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
      count_q <= count_d;
      err_q   <= err_d;
      seen0_q <= seen0_d;
    end
  end

  // NOTE: the captured word is pure data, only read in SCAN after a load, so it carries no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign quota_num = count_q;
  assign mono_err  = err_q;

endmodule

// File: tb/tb_weyl_decode.sv
// Drives weyl_decode with encoder-generated, corrupted and random words; a scoreboard
// derived from the word itself predicts handshakes, latency and results every cycle.
module tb_weyl_decode;
  import weyl_pkg::*;

  localparam int N    = 64;
  localparam int B    = 61;
  localparam int S    = 17;
  localparam int LAT  = N + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] weyl_in;
  logic         out_valid;
  logic         out_ready;
  logic [6:0]   quota_num;
  logic         mono_err;

  weyl_decode #(.BITSTREAM(N), .BASE(B), .STRIDE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weyl_in   (weyl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quota_num (quota_num),
    .mono_err  (mono_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the ideal encoder word for quota q.
  function automatic logic [N-1:0] encode(input int q);
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[weyl_idx(B, S, i, N)] = (i < q);
    return w;
  endfunction

  function automatic int model_count(input logic [N-1:0] w);
    return $countones(w);
  endfunction

  // A word is valid exactly when it is the encoding of its own popcount.
  function automatic bit model_err(input logic [N-1:0] w);
    return (w != encode($countones(w)));
  endfunction

  typedef struct {
    int cnt;
    bit err;
    int hs;
  } exp_t;

  exp_t pend[$];
  int   last_cnt;
  int   last_err;
  int   last_pop_cyc;

  // Scoreboard: one outstanding word at most; result due LAT cycles after its handshake.
  always @(negedge clk) begin
    bit exp_ov, exp_ir;
    exp_t e;
    if (!rst_n) begin
      pend.delete();
    end else begin
      exp_ov = (pend.size() > 0) && ((cyc - pend[0].hs) >= LAT);
      exp_ir = (pend.size() == 0) || (exp_ov && out_ready);
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("in_ready", 64'(in_ready), 64'(exp_ir));
      if (out_valid && exp_ov) begin
        check("quota_num", 64'(quota_num), 64'(pend[0].cnt));
        check("mono_err", 64'(mono_err), 64'(pend[0].err));
      end
      if (exp_ov && out_ready) begin
        last_cnt     = quota_num;
        last_err     = mono_err;
        last_pop_cyc = cyc;
        void'(pend.pop_front());
      end
      if (in_valid && exp_ir) begin
        e.cnt = model_count(weyl_in);
        e.err = model_err(weyl_in);
        e.hs  = cyc;
        pend.push_back(e);
      end
    end
  end

  // Presents w from posedge+1 until accepted; returns the cycles waited before acceptance.
  task automatic send(input logic [N-1:0] w, output int waited);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    weyl_in   = w;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        check("send timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    weyl_in  = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pend.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        check("result timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic run_word(input logic [N-1:0] w);
    int waited;
    send(w, waited);
    wait_done();
  endtask

  initial begin
    logic [N-1:0] w;
    int waited, t0, n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    weyl_in   = '0;

    // Pin the model with hand-derived values.
    check("pin phase0 idx", 64'(weyl_idx(B, S, 0, N)), 61);
    check("pin phase1 idx", 64'(weyl_idx(B, S, 1, N)), 14);
    check("pin enc64", encode(64), 64'hFFFF_FFFF_FFFF_FFFF);
    w = encode(23);
    check("pin enc23 bits", 64'({w[61], w[14]}), 3);
    check("pin enc23 cnt", 64'(model_count(w)), 23);
    check("pin enc23 err", 64'(model_err(w)), 0);
    w = encode(10); w[61] = 1'b0;
    check("pin corrupt cnt", 64'(model_count(w)), 9);
    check("pin corrupt err", 64'(model_err(w)), 1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 0);
    check("reset quota", 64'(quota_num), 0);
    check("reset mono_err", 64'(mono_err), 0);
    check("reset in_ready", 64'(in_ready), 1);

    // q=0 with explicit latency.
    send('0, waited);
    t0 = cyc - 1;
    wait_done();
    check("q0 latency", 64'(last_pop_cyc - t0), LAT);
    check("q0 quota", 64'(last_cnt), 0);
    check("q0 err", 64'(last_err), 0);

    run_word('1);
    check("q64 quota", 64'(last_cnt), 64);
    check("q64 err", 64'(last_err), 0);

    run_word(encode(23));
    check("q23 quota", 64'(last_cnt), 23);

    for (int q = 0; q <= N; q++) run_word(encode(q));

    w = encode(10); w[61] = 1'b0;
    run_word(w);
    check("corrupt quota", 64'(last_cnt), 9);
    check("corrupt err", 64'(last_err), 1);

    w = '0; w[14] = 1'b1;
    run_word(w);
    check("lone quota", 64'(last_cnt), 1);
    check("lone err", 64'(last_err), 1);

    for (int k = 0; k < 12; k++) run_word({$urandom, $urandom});
    for (int k = 0; k < 12; k++) begin
      w = encode($urandom_range(0, N));
      w[$urandom_range(0, N - 1)] ^= 1'b1;
      run_word(w);
    end

    // Backpressure: result held 20 cycles, then next word accepted alongside the result.
    send(encode(30), waited);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp reached done", 64'(out_valid), 1);
    repeat (20) begin
      @(negedge clk);
      check("bp hold quota", 64'(quota_num), 30);
      check("bp in_ready low", 64'(in_ready), 0);
    end
    send(encode(47), waited);
    check("bp same-cycle accept", 64'(waited), 0);
    check("bp first result", 64'(last_cnt), 30);
    wait_done();
    check("bp second result", 64'(last_cnt), 47);

    // Reset in the middle of a scan discards the word.
    send(encode(40), waited);
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst out_valid", 64'(out_valid), 0);
    check("midrst quota", 64'(quota_num), 0);
    check("midrst in_ready", 64'(in_ready), 1);
    run_word(encode(5));
    check("post-reset q5", 64'(last_cnt), 5);
    check("post-reset err", 64'(last_err), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
